fb_read_sched: RTL and testbench
================================

Name: fb_read_sched

Overview:
Scheduler for the framebuffer BRAM read port in the system clock domain. Sequences one linebuffer fill (FB_WIDTH consecutive reads) at the first screen line of every FB_SCALE group. Between fills, grants the same read port to a secondary requester (drawing engine / readback) over a valid/ready handshake. Sits between the xd-synchronised display flags, the bram_sdp read port and linebuffer_simple's input side.

Parameters:
FB_WIDTH, 160, framebuffer width in pixels (reads per fill)
FB_HEIGHT, 120, framebuffer height in rows (fills per frame)
FB_SCALE, 5, screen lines per framebuffer row (1-63)
FB_ADDRW, $clog2(FB_WIDTH*FB_HEIGHT), framebuffer address width
FB_DATAW, 4, bits per framebuffer pixel
LAT_BRAM, 1, BRAM read latency in cycles (1-2)

Ports:
clk_sys  input  1  system clock
rst_sys  input  1  synchronous active-high reset
frame_sys  input  1  frame-start pulse (already in clk_sys)
line_sys  input  1  line-start pulse
line0_sys  input  1  line-start pulse for sy==0
fb_addr_read  output  FB_ADDRW  BRAM read address
fb_colr_read  input  FB_DATAW  BRAM read data
lb_en_in  output  1  linebuffer write enable, aligned with lb_data_in
lb_data_in  output  FB_DATAW  pixel to linebuffer
req_valid  input  1  requester read request
req_addr  input  FB_ADDRW  requester address
req_ready  output  1  request accepted this cycle
rsp_valid  output  1  requester data valid (1 cycle)
rsp_data  output  FB_DATAW  requester read data
busy  output  1  fill in progress (FILL or FLUSH)
underrun  output  1  1-cycle pulse: line_sys arrived while busy

Behaviour:
- Reset: state IDLE; all outputs 0; fb_addr_read=0; row_base=0; rows_done=0; cnt_line=0; lb_active=0; read-tag pipeline cleared.
- Line counter cnt_line (width $clog2(FB_SCALE)+1): line0_sys -> 0 and lb_active=1; else line_sys -> wrap at FB_SCALE-1 to 0, else +1. frame_sys -> lb_active=0, row_base=0, rows_done=0.
- Fill trigger: line_sys, and the next cnt_line is 0, and lb_active, and rows_done<FB_HEIGHT. line0_sys counts as a trigger with cnt_line=0.
- States:
  IDLE: serve requester; trigger -> FILL next cycle.
  FILL: issue one read per cycle at row_base+cnt_x, cnt_x from 0 to FB_WIDTH-1; after the last issue go to FLUSH.
  FLUSH: hold for LAT_BRAM cycles; then row_base+=FB_WIDTH, rows_done+=1, return to IDLE.
- Read pipeline: each issued read carries a tag (FILL/REQ) delayed by LAT_BRAM.
  - FILL tag: lb_en_in=1, lb_data_in=fb_colr_read.
  - REQ tag: rsp_valid=1, rsp_data=fb_colr_read.
  - Exactly FB_WIDTH lb_en_in pulses per fill, contiguous.
- Handshake: req_ready = (state==IDLE) && !trigger && !rst_sys (combinational). Transfer on req_valid&&req_ready; fb_addr_read=req_addr that cycle. rsp_valid follows exactly LAT_BRAM cycles after acceptance. At most one request per cycle, fully pipelined. Fill always wins over the requester.
- When idle with no transfer, fb_addr_read holds its last value.
- busy = state in {FILL, FLUSH}.
- underrun: pulse if line_sys while busy. The running fill completes unaltered; the trigger from that line is dropped, but cnt_line still advances.
- frame_sys mid-fill: abort to IDLE next cycle, clear FILL tags in the pipeline (no further lb_en_in), keep REQ tags. frame_sys together with line0_sys in the same cycle: frame_sys acts first, then line0_sys re-enables lb_active and triggers.
- rows_done saturates at FB_HEIGHT; no fill issues beyond the last row. row_base never exceeds FB_WIDTH*(FB_HEIGHT-1).
- Reset mid-operation: immediate return to reset values, including pipeline tags.

Optional Feature:
- FB_READ_SCHED_STATS_EN defined: adds output ports underrun_cnt[7:0] and req_stall_cnt[15:0].
  - underrun_cnt: saturating count of underrun pulses.
  - req_stall_cnt: saturating count of cycles with req_valid&&!req_ready.
  - Both clear on frame_sys and on rst_sys.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fb_pkg: typedef enum {IDLE, FILL, FLUSH} sched_state_t; typedef enum logic {TAG_FILL, TAG_REQ} rd_tag_t; shared constants FB_WIDTH/FB_HEIGHT/FB_SCALE defaults.
- Sub-module rd_tag_pipe: LAT_BRAM-deep valid+tag shift register with a selective flush of FILL tags.

Test Plan:
- Reset release, then line0_sys, FB_WIDTH=160, LAT_BRAM=1 -> FILL begins the next cycle; addresses 0..159; 160 contiguous lb_en_in one cycle later; busy high 161 cycles.
- 5 further line_sys pulses (FB_SCALE=5) -> second fill only on the 5th, addresses 160..319; no lb_en_in on the 4 intermediate lines.
- req_valid held high across a trigger -> req_ready drops the trigger cycle and through FILL/FLUSH; each accepted req_addr=0x1234 yields rsp_valid exactly one cycle later with the BRAM content.
- line_sys injected at cnt_x=80 of a fill -> underrun one pulse; all 160 lb_en_in still delivered; the next fill is at the correct row.
- frame_sys at cnt_x=50 -> lb_en_in stops within LAT_BRAM cycles; row_base=0; the next line0_sys refills from address 0.
- 600 screen lines after line0_sys -> exactly 120 fills; the last row starts at 19040; no reads beyond address 19199.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer read scheduler.
package fb_pkg;

  localparam int FB_WIDTH_DEF  = 160;
  localparam int FB_HEIGHT_DEF = 120;
  localparam int FB_SCALE_DEF  = 5;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} sched_state_t;
  typedef enum logic {TAG_FILL, TAG_REQ} rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid+tag delay line matching the BRAM read latency; can drop in-flight
// FILL entries while letting REQ entries through.
module rd_tag_pipe
  import fb_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  rd_tag_t in_tag,
  input  logic    flush_fill,
  output logic    out_valid,
  output rd_tag_t out_tag
);

  logic [LAT-1:0] vld_q, vld_d;
  rd_tag_t        tag_q [LAT];
  rd_tag_t        tag_d [LAT];

  always_comb begin
    vld_d[0] = in_valid;
    tag_d[0] = in_tag;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    if (flush_fill) begin
      for (int i = 0; i < LAT; i++) begin
        if (tag_d[i] == TAG_FILL) vld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= TAG_FILL;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_tag   = tag_q[LAT-1];

endmodule

// File: rtl/fb_read_sched.sv
// Framebuffer BRAM read-port scheduler: linebuffer fills win over a secondary requester.
// Optional FB_READ_SCHED_STATS_EN adds underrun_cnt / req_stall_cnt outputs.
//
// state | meaning
// IDLE  | port granted to requester, waiting for a fill trigger
// FILL  | issuing FB_WIDTH consecutive reads of the current row
// FLUSH | waiting LAT_BRAM cycles for the last fill data, then advance row
module fb_read_sched
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int FB_SCALE  = FB_SCALE_DEF,
  parameter int FB_ADDRW  = $clog2(FB_WIDTH*FB_HEIGHT),
  parameter int FB_DATAW  = 4,
  parameter int LAT_BRAM  = 1
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  input  logic                frame_sys,
  input  logic                line_sys,
  input  logic                line0_sys,
  output logic [FB_ADDRW-1:0] fb_addr_read,
  input  logic [FB_DATAW-1:0] fb_colr_read,
  output logic                lb_en_in,
  output logic [FB_DATAW-1:0] lb_data_in,
  input  logic                req_valid,
  input  logic [FB_ADDRW-1:0] req_addr,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [FB_DATAW-1:0] rsp_data,
  output logic                busy,
  output logic                underrun
`ifdef FB_READ_SCHED_STATS_EN
  ,
  output logic [7:0]          underrun_cnt,
  output logic [15:0]         req_stall_cnt
`endif
);

  localparam int CW = $clog2(FB_SCALE) + 1;
  localparam int XW = $clog2(FB_WIDTH + 1);
  localparam int RW = $clog2(FB_HEIGHT + 1);

  sched_state_t        state_q, state_d;
  logic [XW-1:0]       cnt_x_q, cnt_x_d;
  logic [1:0]          flush_cnt_q, flush_cnt_d;
  logic [FB_ADDRW-1:0] row_base_q, row_base_d;
  logic [RW-1:0]       rows_done_q, rows_done_d;
  logic [CW-1:0]       cnt_line_q, cnt_line_d;
  logic                lb_active_q, lb_active_d;
  logic [FB_ADDRW-1:0] addr_q, addr_d;
  logic                underrun_q, underrun_d;

  logic                trigger, fill_start, fill_issue, req_fire;
  logic [RW-1:0]       rows_eff;
  logic [FB_ADDRW-1:0] base_eff;
  logic                pipe_valid;
  rd_tag_t             pipe_tag;

  always_comb begin
    lb_active_d = line0_sys | (lb_active_q & ~frame_sys);
    rows_eff    = frame_sys ? '0 : rows_done_q;
    base_eff    = frame_sys ? '0 : row_base_q;
    if (line0_sys)     cnt_line_d = '0;
    else if (line_sys) cnt_line_d = (cnt_line_q == CW'(FB_SCALE - 1)) ? '0 : cnt_line_q + CW'(1);
    else               cnt_line_d = cnt_line_q;
    // frame_sys is applied before evaluating the trigger so frame+line0 refills at once
    trigger    = (line_sys | line0_sys) && (cnt_line_d == '0) && lb_active_d &&
                 (rows_eff < RW'(FB_HEIGHT));
    fill_start = trigger && ((state_q == IDLE) || frame_sys);
    req_ready  = (state_q == IDLE) && !trigger && !rst_sys;
    req_fire   = req_valid && req_ready;
    fill_issue = (state_q == FILL) && !frame_sys && !rst_sys;
    underrun_d = line_sys && (state_q != IDLE);

    if (fill_issue)    addr_d = row_base_q + FB_ADDRW'(cnt_x_q);
    else if (req_fire) addr_d = req_addr;
    else               addr_d = addr_q;

    state_d     = state_q;
    cnt_x_d     = cnt_x_q;
    flush_cnt_d = flush_cnt_q;
    row_base_d  = base_eff;
    rows_done_d = rows_eff;
    if (frame_sys) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        FILL: begin
          cnt_x_d = cnt_x_q + XW'(1);
          if (cnt_x_q == XW'(FB_WIDTH - 1)) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
        FLUSH: begin
          flush_cnt_d = flush_cnt_q + 2'd1;
          if (flush_cnt_q == 2'(LAT_BRAM - 1)) begin
            state_d = IDLE;
            if (rows_done_q < RW'(FB_HEIGHT - 1)) row_base_d = row_base_q + FB_ADDRW'(FB_WIDTH);
            if (rows_done_q < RW'(FB_HEIGHT))     rows_done_d = rows_done_q + RW'(1);
          end
        end
        default: ;
      endcase
    end
    if (fill_start) begin
      state_d = FILL;
      cnt_x_d = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q     <= IDLE;
      cnt_x_q     <= '0;
      flush_cnt_q <= '0;
      row_base_q  <= '0;
      rows_done_q <= '0;
      cnt_line_q  <= '0;
      lb_active_q <= 1'b0;
      addr_q      <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_x_q     <= cnt_x_d;
      flush_cnt_q <= flush_cnt_d;
      row_base_q  <= row_base_d;
      rows_done_q <= rows_done_d;
      cnt_line_q  <= cnt_line_d;
      lb_active_q <= lb_active_d;
      addr_q      <= addr_d;
      underrun_q  <= underrun_d;
    end
  end

  rd_tag_pipe #(.LAT(LAT_BRAM)) u_tag_pipe (
    .clk        (clk_sys),
    .rst        (rst_sys),
    .in_valid   (fill_issue | req_fire),
    .in_tag     (fill_issue ? TAG_FILL : TAG_REQ),
    .flush_fill (frame_sys),
    .out_valid  (pipe_valid),
    .out_tag    (pipe_tag)
  );

  assign fb_addr_read = rst_sys ? '0 : addr_d;
  assign lb_en_in     = !rst_sys && pipe_valid && (pipe_tag == TAG_FILL);
  assign lb_data_in   = lb_en_in ? fb_colr_read : '0;
  assign rsp_valid    = !rst_sys && pipe_valid && (pipe_tag == TAG_REQ);
  assign rsp_data     = rsp_valid ? fb_colr_read : '0;
  assign busy         = !rst_sys && (state_q != IDLE);
  assign underrun     = !rst_sys && underrun_q;

`ifdef FB_READ_SCHED_STATS_EN
  logic [7:0]  underrun_cnt_q;
  logic [15:0] req_stall_cnt_q;

  always_ff @(posedge clk_sys) begin
    if (rst_sys || frame_sys) begin
      underrun_cnt_q  <= '0;
      req_stall_cnt_q <= '0;
    end else begin
      if (underrun_q && underrun_cnt_q != 8'hff) underrun_cnt_q <= underrun_cnt_q + 8'd1;
      if (req_valid && !req_ready && req_stall_cnt_q != 16'hffff)
        req_stall_cnt_q <= req_stall_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt  = underrun_cnt_q;
  assign req_stall_cnt = req_stall_cnt_q;
`endif

endmodule

// File: tb/tb_fb_read_sched.sv
// Scoreboard bench for fb_read_sched: fill data and requester responses are
// predicted from a behavioural BRAM image and a line/row model.
module tb_fb_read_sched;
  import fb_pkg::*;

  localparam int W   = 160;
  localparam int H   = 120;
  localparam int S   = 5;
  localparam int AW  = $clog2(W*H);
  localparam int DW  = 4;
  localparam int LAT = 1;

  logic          clk_sys = 1'b0;
  logic          rst_sys, frame_sys, line_sys, line0_sys;
  logic [AW-1:0] fb_addr_read;
  logic [DW-1:0] fb_colr_read;
  logic          lb_en_in;
  logic [DW-1:0] lb_data_in;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy, underrun;
`ifdef FB_READ_SCHED_STATS_EN
  logic [7:0]    underrun_cnt;
  logic [15:0]   req_stall_cnt;
`endif

  always #5 clk_sys = ~clk_sys;

  fb_read_sched #(.FB_WIDTH(W), .FB_HEIGHT(H), .FB_SCALE(S), .FB_ADDRW(AW),
                  .FB_DATAW(DW), .LAT_BRAM(LAT)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .frame_sys(frame_sys), .line_sys(line_sys),
    .line0_sys(line0_sys), .fb_addr_read(fb_addr_read), .fb_colr_read(fb_colr_read),
    .lb_en_in(lb_en_in), .lb_data_in(lb_data_in), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .underrun(underrun)
`ifdef FB_READ_SCHED_STATS_EN
    , .underrun_cnt(underrun_cnt), .req_stall_cnt(req_stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return DW'(a ^ (a >> 4) ^ (a >> 9));
  endfunction

  always @(posedge clk_sys) fb_colr_read <= mem_f(fb_addr_read);

  int            tests = 0, fails = 0, cyc = 0;
  int            lb_cnt = 0, lb_first = 0, lb_last = 0;
  int            underrun_seen = 0, fills_seen = 0, rsp_seen = 0;
  logic          prev_accept = 1'b0, busy_d = 1'b0;
  logic [DW-1:0] lb_q [$];
  logic [DW-1:0] rsp_q [$];
  logic [DW-1:0] exp_v;
  int            m_cnt, m_active, m_rows, m_base;

  always @(negedge clk_sys) begin
    cyc++;
    if (rst_sys) begin
      prev_accept = 1'b0;
      busy_d      = 1'b0;
    end else begin
      if (lb_en_in) begin
        lb_cnt++;
        if (lb_cnt == 1) lb_first = cyc;
        lb_last = cyc;
        tests++;
        if (lb_q.size() == 0) begin
          fails++;
          $display("FAIL lb_extra: lb_en_in=1 data=%0h, required no write", lb_data_in);
        end else begin
          exp_v = lb_q.pop_front();
          if (lb_data_in !== exp_v) begin
            fails++;
            $display("FAIL lb_data: got %0h required %0h", lb_data_in, exp_v);
          end
        end
      end
      tests++;
      if (rsp_valid !== prev_accept) begin
        fails++;
        $display("FAIL rsp_timing: rsp_valid=%0b required %0b", rsp_valid, prev_accept);
      end
      if (rsp_valid && rsp_q.size() != 0) begin
        rsp_seen++;
        exp_v = rsp_q.pop_front();
        tests++;
        if (rsp_data !== exp_v) begin
          fails++;
          $display("FAIL rsp_data: got %0h required %0h", rsp_data, exp_v);
        end
      end
      prev_accept = req_valid && req_ready;
      if (prev_accept) rsp_q.push_back(mem_f(req_addr));
      if (busy) begin
        tests++;
        if (req_ready !== 1'b0 || fb_addr_read > AW'(W*H-1)) begin
          fails++;
          $display("FAIL busy_port: req_ready=%0b addr=%0d required ready=0 addr<=%0d",
                   req_ready, fb_addr_read, W*H-1);
        end
      end
      if (underrun) underrun_seen++;
      if (busy && !busy_d) fills_seen++;
      busy_d = busy;
    end
  end

  task automatic line_pulse(input bit l0, input bit frm, output bit trig, output int base);
    if (frm) begin m_active = 0; m_rows = 0; m_base = 0; end
    if (l0) begin m_cnt = 0; m_active = 1; end
    else m_cnt = (m_cnt == S-1) ? 0 : m_cnt + 1;
    trig = (m_cnt == 0) && (m_active != 0) && (m_rows < H);
    base = m_base;
    if (trig) begin
      for (int i = 0; i < W; i++) lb_q.push_back(mem_f(AW'(m_base + i)));
      if (m_rows < H-1) m_base += W;
      m_rows++;
    end
    line_sys = 1'b1; line0_sys = l0; frame_sys = frm;
    @(negedge clk_sys);
    tests++;
    if (req_ready !== !trig) begin
      fails++;
      $display("FAIL line_ready: req_ready=%0b required %0b", req_ready, !trig);
    end
    @(posedge clk_sys); #1;
    line_sys = 1'b0; line0_sys = 1'b0; frame_sys = 1'b0;
  endtask

  // Entered at the start of the first FILL cycle.
  task automatic fill_check(input int base, input int inj, input int frm_at);
    int abort_cyc;
    lb_cnt = 0;
    for (int i = 0; i < W; i++) begin
      line_sys  = (i == inj);
      frame_sys = (i == frm_at);
      if (i == inj) m_cnt = (m_cnt == S-1) ? 0 : m_cnt + 1;
      @(negedge clk_sys);
      tests++;
      if (busy !== 1'b1 || (i != frm_at && fb_addr_read !== AW'(base + i))) begin
        fails++;
        $display("FAIL fill_addr: i=%0d busy=%0b addr=%0d required busy=1 addr=%0d",
                 i, busy, fb_addr_read, base + i);
      end
      if (i == frm_at) begin
        abort_cyc = cyc;
        m_active = 0; m_rows = 0; m_base = 0;
        @(posedge clk_sys); #1;
        frame_sys = 1'b0;
        @(negedge clk_sys);
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL abort_busy: busy=%0b required 0", busy);
        end
        repeat (3) @(negedge clk_sys);
        tests++;
        if (lb_cnt < frm_at || lb_last > abort_cyc + LAT) begin
          fails++;
          $display("FAIL abort_lb: writes=%0d last=%0d required >=%0d and last<=%0d",
                   lb_cnt, lb_last, frm_at, abort_cyc + LAT);
        end
        lb_q.delete();
        @(posedge clk_sys); #1;
        return;
      end
      @(posedge clk_sys); #1;
    end
    line_sys = 1'b0;
    @(negedge clk_sys);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL flush_busy: busy=%0b required 1", busy);
    end
    @(posedge clk_sys); #1;
    @(negedge clk_sys);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL fill_end: busy=%0b required 0 after %0d cycles", busy, W + LAT);
    end
    tests++;
    if (lb_cnt != W || lb_last - lb_first != W-1 || lb_q.size() != 0) begin
      fails++;
      $display("FAIL lb_burst: writes=%0d span=%0d pending=%0d required %0d contiguous",
               lb_cnt, lb_last - lb_first + 1, lb_q.size(), W);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic line_and_fill(input bit l0, input bit frm);
    bit trig; int base;
    line_pulse(l0, frm, trig, base);
    if (trig) fill_check(base, -1, -1);
    else begin
      @(negedge clk_sys);
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL no_fill: busy=%0b required 0", busy);
      end
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic test_reset;
    rst_sys = 1'b1; req_valid = 1'b1; req_addr = AW'(16'h1234);
    repeat (3) begin
      @(negedge clk_sys);
      tests++;
      if (busy !== 0 || lb_en_in !== 0 || rsp_valid !== 0 || underrun !== 0 ||
          fb_addr_read !== '0 || req_ready !== 0) begin
        fails++;
        $display("FAIL reset_out: busy=%0b lb=%0b rsp=%0b un=%0b addr=%0d rdy=%0b required all 0",
                 busy, lb_en_in, rsp_valid, underrun, fb_addr_read, req_ready);
      end
    end
    @(posedge clk_sys); #1;
    rst_sys = 1'b0; req_valid = 1'b0;
    m_cnt = 0; m_active = 0; m_rows = 0; m_base = 0;
    @(negedge clk_sys);
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: req_ready=%0b busy=%0b required 1 0", req_ready, busy);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_first_fill;
    line_and_fill(1'b1, 1'b0);
  endtask

  task automatic test_scale;
    lb_cnt = 0;
    repeat (S) line_and_fill(1'b0, 1'b0);
  endtask

  task automatic test_req_during_fill;
    req_valid = 1'b1; req_addr = AW'(16'h1234); rsp_seen = 0;
    repeat (4) @(posedge clk_sys);
    #1;
    repeat (S) line_and_fill(1'b0, 1'b0);
    @(negedge clk_sys);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_resume: req_ready=%0b required 1", req_ready);
    end
    @(posedge clk_sys); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    tests++;
    if (rsp_q.size() != 0 || rsp_seen < 8) begin
      fails++;
      $display("FAIL req_rsp: pending=%0d seen=%0d required 0 pending, >=8 seen",
               rsp_q.size(), rsp_seen);
    end
  endtask

  task automatic test_underrun;
    bit trig; int base;
    underrun_seen = 0;
    repeat (S-1) line_and_fill(1'b0, 1'b0);
    line_pulse(1'b0, 1'b0, trig, base);
    fill_check(base, 80, -1);
    tests++;
    if (underrun_seen != 1) begin
      fails++;
      $display("FAIL underrun: pulses=%0d required 1", underrun_seen);
    end
`ifdef FB_READ_SCHED_STATS_EN
    tests++;
    if (underrun_cnt !== 8'd1) begin
      fails++;
      $display("FAIL underrun_cnt: got %0d required 1", underrun_cnt);
    end
`endif
    repeat (S-1) line_and_fill(1'b0, 1'b0);
  endtask

  task automatic test_frame_abort;
    bit trig; int base;
    repeat (S-1) line_and_fill(1'b0, 1'b0);
    line_pulse(1'b0, 1'b0, trig, base);
    fill_check(base, -1, 50);
    repeat (S) line_and_fill(1'b0, 1'b0);
    line_and_fill(1'b1, 1'b0);
  endtask

  task automatic test_full_frame;
    fills_seen = 0;
    line_and_fill(1'b1, 1'b1);
    repeat (599) line_and_fill(1'b0, 1'b0);
    repeat (2*S) line_and_fill(1'b0, 1'b0);
    line_and_fill(1'b1, 1'b0);
    tests++;
    if (fills_seen != H) begin
      fails++;
      $display("FAIL frame_fills: got %0d required %0d", fills_seen, H);
    end
  endtask

  task automatic test_reset_mid;
    bit trig; int base;
    line_pulse(1'b1, 1'b1, trig, base);
    repeat (30) @(posedge clk_sys);
    #1;
    rst_sys = 1'b1;
    lb_q.delete();
    repeat (2) begin
      @(negedge clk_sys);
      tests++;
      if (busy !== 0 || lb_en_in !== 0 || fb_addr_read !== '0 || rsp_valid !== 0) begin
        fails++;
        $display("FAIL mid_reset: busy=%0b lb=%0b addr=%0d rsp=%0b required all 0",
                 busy, lb_en_in, fb_addr_read, rsp_valid);
      end
    end
    @(posedge clk_sys); #1;
    rst_sys = 1'b0;
    m_cnt = 0; m_active = 0; m_rows = 0; m_base = 0;
    lb_cnt = 0;
    line_and_fill(1'b0, 1'b0);
    line_and_fill(1'b1, 1'b0);
  endtask

  initial begin
    rst_sys = 1'b1; frame_sys = 1'b0; line_sys = 1'b0; line0_sys = 1'b0;
    req_valid = 1'b0; req_addr = '0;
    test_reset;
    test_first_fill;
    test_scale;
    test_req_during_fill;
    test_underrun;
    test_frame_abort;
    test_full_frame;
    test_reset_mid;
    repeat (3) @(posedge clk_sys);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
